// File: rtl/memio_pkg.sv
// Shared types and constants for the memio_bus CPU-side memory/IO bridge.
package memio_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      MEM_WAIT = 2'b01,
      IO_REQ   = 2'b10,
      DONE     = 2'b11
   } state_t;

   localparam logic [1:0] BYTE = 2'b00;
   localparam logic [1:0] HALF = 2'b01;
   localparam logic [1:0] WORD = 2'b11;

   localparam int unsigned IO_TIMEOUT = 255;
   localparam int unsigned DM_AW      = 14;
   localparam int unsigned IO_AW      = 10;

   // Illegal: several strobes at once, reserved width, or misaligned half/word.
   function automatic logic illegal_req(input logic [3:0] strobes,
                                        input logic [1:0] width,
                                        input logic [1:0] off);
      logic multi;
      multi = (strobes & (strobes - 4'd1)) != '0;
      return multi || (width == 2'b10) ||
             ((width == WORD) && (off != '0)) ||
             ((width == HALF) && off[0]);
   endfunction

endpackage

// File: rtl/memio_bus_if.sv
// CPU request, data-memory and IO-bus signals of memio_bus, with bridge/driver views.
interface memio_bus_if;
   import memio_pkg::*;

   logic                 MemRead, MemWrite, IORead, IOWrite;
   logic [31:0]          addr, wdata;
   logic [1:0]           Mem_Dwidth;
   logic                 Mem_sign;
   logic [31:0]          rdata;
   logic                 stall, addr_err, bus_err;

   logic                 dm_en;
   logic [3:0]           dm_we;
   logic [DM_AW-1:0]     dm_addr;
   logic [31:0]          dm_wdata, dm_rdata;

   logic                 io_req, io_we;
   logic [IO_AW-1:0]     io_addr;
   logic [3:0]           io_be;
   logic [31:0]          io_wdata, io_rdata;
   logic                 io_ack;

   modport slave (
      input  MemRead, MemWrite, IORead, IOWrite, addr, wdata, Mem_Dwidth, Mem_sign,
      output rdata, stall, addr_err, bus_err,
      output dm_en, dm_we, dm_addr, dm_wdata,
      input  dm_rdata,
      output io_req, io_we, io_addr, io_be, io_wdata,
      input  io_rdata, io_ack
   );

   modport master (
      output MemRead, MemWrite, IORead, IOWrite, addr, wdata, Mem_Dwidth, Mem_sign,
      input  rdata, stall, addr_err, bus_err,
      input  dm_en, dm_we, dm_addr, dm_wdata,
      output dm_rdata,
      input  io_req, io_we, io_addr, io_be, io_wdata,
      output io_rdata, io_ack
   );

endinterface

// File: rtl/memio_lane.sv
// Byte-lane logic: lane mask, store replication and little-endian load extraction.
module memio_lane
   import memio_pkg::*;
(
   input  logic [1:0]  width,
   input  logic [1:0]  offset,
   input  logic        sign_ext,
   input  logic [31:0] data,
   output logic [3:0]  mask,
   output logic [31:0] store,
   output logic [31:0] load
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      mask  = '0;
      store = data;
      load  = data;
      b     = data[{offset, 3'b000} +: 8];
      h     = offset[1] ? data[31:16] : data[15:0];
      case (width)
         BYTE: begin
            mask  = 4'b0001 << offset;
            store = {4{data[7:0]}};
            load  = {{24{sign_ext & b[7]}}, b};
         end
         HALF: begin
            mask  = offset[1] ? 4'b1100 : 4'b0011;
            store = {2{data[15:0]}};
            load  = {{16{sign_ext & h[15]}}, h};
         end
         WORD: begin
            mask  = '1;
         end
         default: begin
            mask  = '0;
            load  = '0;
         end
      endcase
   end

endmodule

// File: rtl/memio_bus.sv
// Bridges CPU load/store strobes to a single-cycle data memory and an acked IO bus.
module memio_bus
   import memio_pkg::*;
(
   input  logic      clock,
   input  logic      reset,
   memio_bus_if.slave bus
);

   state_t           state, state_nxt;
   logic [3:0]       strobes;
   logic             req, illegal, timeout;
   logic [7:0]       cnt;

   logic [1:0]       lat_width, lat_off;
   logic             lat_sign, lat_io_rd;

   logic [3:0]       st_mask;
   logic [31:0]      st_data;
   logic [31:0]      ld_raw, ld_ext;

   logic [31:0]      rdata_q;
   logic             io_req_q, io_we_q;
   logic [IO_AW-1:0] io_addr_q;
   logic [3:0]       io_be_q;
   logic [31:0]      io_wdata_q;

   logic             addr_err_c, bus_err_c, dm_en_c;
   logic [3:0]       dm_we_c;

   assign strobes = {bus.MemRead, bus.MemWrite, bus.IORead, bus.IOWrite};
   assign req     = |strobes;
   assign illegal = illegal_req(strobes, bus.Mem_Dwidth, bus.addr[1:0]);
   assign timeout = (cnt == 8'(IO_TIMEOUT - 1));

   // Store side works on live CPU inputs; load side on the parameters latched at acceptance.
   memio_lane u_store (
      .width    (bus.Mem_Dwidth),
      .offset   (bus.addr[1:0]),
      .sign_ext (bus.Mem_sign),
      .data     (bus.wdata),
      .mask     (st_mask),
      .store    (st_data),
      .load     ()
   );

   assign ld_raw = (state == IO_REQ) ? bus.io_rdata : bus.dm_rdata;

   memio_lane u_load (
      .width    (lat_width),
      .offset   (lat_off),
      .sign_ext (lat_sign),
      .data     (ld_raw),
      .mask     (),
      .store    (),
      .load     (ld_ext)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      addr_err_c = 1'b0;
      bus_err_c  = 1'b0;
      dm_en_c    = 1'b0;
      dm_we_c    = '0;
      case (state)
         IDLE: begin
            if (req) begin
               if (illegal) begin
                  addr_err_c = 1'b1;
                  state_nxt  = DONE;
               end else if (bus.MemRead) begin
                  dm_en_c   = 1'b1;
                  state_nxt = MEM_WAIT;
               end else if (bus.MemWrite) begin
                  dm_en_c   = 1'b1;
                  dm_we_c   = st_mask;
                  state_nxt = DONE;
               end else begin
                  state_nxt = IO_REQ;
               end
            end
         end
         MEM_WAIT: state_nxt = DONE;
         IO_REQ: begin
            if (bus.io_ack) begin
               state_nxt = DONE;
            end else if (timeout) begin
               bus_err_c = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt        <= '0;
         rdata_q    <= '0;
         io_req_q   <= 1'b0;
         io_we_q    <= 1'b0;
         io_addr_q  <= '0;
         io_be_q    <= '0;
         io_wdata_q <= '0;
         lat_width  <= '0;
         lat_off    <= '0;
         lat_sign   <= 1'b0;
         lat_io_rd  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  lat_width <= bus.Mem_Dwidth;
                  lat_off   <= bus.addr[1:0];
                  lat_sign  <= bus.Mem_sign;
                  lat_io_rd <= bus.IORead;
                  cnt       <= '0;
                  if (illegal) begin
                     rdata_q <= '0;
                  end else if (bus.IORead || bus.IOWrite) begin
                     io_req_q   <= 1'b1;
                     io_we_q    <= bus.IOWrite;
                     io_addr_q  <= bus.addr[IO_AW-1:0];
                     io_be_q    <= st_mask;
                     io_wdata_q <= st_data;
                  end
               end
            end
            MEM_WAIT: rdata_q <= ld_ext;
            IO_REQ: begin
               if (bus.io_ack) begin
                  io_req_q <= 1'b0;
                  if (lat_io_rd) rdata_q <= ld_ext;
               end else if (timeout) begin
                  io_req_q <= 1'b0;
                  rdata_q  <= '0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.rdata    = rdata_q;
   assign bus.stall    = req && (state != DONE);
   assign bus.addr_err = addr_err_c;
   assign bus.bus_err  = bus_err_c;
   assign bus.dm_en    = dm_en_c;
   assign bus.dm_we    = dm_we_c;
   assign bus.dm_addr  = bus.addr[DM_AW+1:2];
   assign bus.dm_wdata = st_data;
   assign bus.io_req   = io_req_q;
   assign bus.io_we    = io_we_q;
   assign bus.io_addr  = io_addr_q;
   assign bus.io_be    = io_be_q;
   assign bus.io_wdata = io_wdata_q;

endmodule

// File: tb/tb_memio_bus.sv
// Directed self-checking bench for memio_bus: memory, IO, timeout, illegal and reset cases.
module tb_memio_bus;

   logic clock;
   logic reset;
   int   n_cmp;
   int   n_err;
   int   n;

   memio_bus_if bus ();

   memio_bus dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Counts cycles with stall high, bounded so a stuck DUT still reaches the summary.
   task automatic run_stall(output int cycles);
      cycles = 0;
      while (bus.stall === 1'b1 && cycles < 400) begin
         cycles++;
         step();
      end
   endtask

   task automatic end_access();
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.IORead   = 1'b0;
      bus.IOWrite  = 1'b0;
      step();
   endtask

   task automatic mem_read(input string tag, input logic [31:0] a, input logic [1:0] w,
                           input logic s, input logic [31:0] raw, input logic [31:0] exp);
      int c;
      bus.addr       = a;
      bus.Mem_Dwidth = w;
      bus.Mem_sign   = s;
      bus.dm_rdata   = raw;
      bus.MemRead    = 1'b1;
      #1;
      chk({tag, "_dm_en"}, 32'(bus.dm_en), 32'd1);
      chk({tag, "_dm_addr"}, 32'(bus.dm_addr), 32'(a[15:2]));
      run_stall(c);
      chk({tag, "_stall_cycles"}, c, 32'd2);
      chk({tag, "_rdata"}, bus.rdata, exp);
      end_access();
   endtask

   initial begin
      int io_cycles;
      int berr_cnt;
      n_cmp = 0;
      n_err = 0;
      reset          = 1'b1;
      bus.MemRead    = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.IORead     = 1'b0;
      bus.IOWrite    = 1'b0;
      bus.addr       = '0;
      bus.wdata      = '0;
      bus.Mem_Dwidth = 2'b11;
      bus.Mem_sign   = 1'b0;
      bus.dm_rdata   = '0;
      bus.io_rdata   = '0;
      bus.io_ack     = 1'b0;

      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      step();
      chk("rst_stall", 32'(bus.stall), 32'd0);
      chk("rst_addr_err", 32'(bus.addr_err), 32'd0);
      chk("rst_bus_err", 32'(bus.bus_err), 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      chk("rst_io_req", 32'(bus.io_req), 32'd0);
      chk("rst_io_addr", 32'(bus.io_addr), 32'd0);

      // Loads: byte signed, byte unsigned, half signed, word
      mem_read("ld_b_s", 32'h0000_0013, 2'b00, 1'b1, 32'h80FF_1234, 32'hFFFF_FF80);
      mem_read("ld_b_u", 32'h0000_0012, 2'b00, 1'b0, 32'h80FF_1234, 32'h0000_00FF);
      mem_read("ld_h_s", 32'h0000_0002, 2'b01, 1'b1, 32'h80FF_1234, 32'hFFFF_80FF);
      mem_read("ld_w",   32'h0000_0004, 2'b11, 1'b1, 32'h80FF_1234, 32'h80FF_1234);

      // Half store at upper half
      bus.addr = 32'h0000_0022; bus.Mem_Dwidth = 2'b01; bus.wdata = 32'h0000_BEEF;
      bus.MemWrite = 1'b1;
      #1;
      chk("st_h_dm_en", 32'(bus.dm_en), 32'd1);
      chk("st_h_dm_we", 32'(bus.dm_we), 32'b1100);
      chk("st_h_dm_wdata", bus.dm_wdata, 32'hBEEF_BEEF);
      chk("st_h_dm_addr", 32'(bus.dm_addr), 32'h008);
      run_stall(n);
      chk("st_h_stall_cycles", n, 32'd1);
      chk("st_h_dm_we_after", 32'(bus.dm_we), 32'd0);
      chk("st_h_dm_en_after", 32'(bus.dm_en), 32'd0);
      end_access();

      // Byte store in lane 1
      bus.addr = 32'h0000_0001; bus.Mem_Dwidth = 2'b00; bus.wdata = 32'h1234_5678;
      bus.MemWrite = 1'b1;
      #1;
      chk("st_b_dm_we", 32'(bus.dm_we), 32'b0010);
      chk("st_b_dm_wdata", bus.dm_wdata, 32'h7878_7878);
      run_stall(n);
      chk("st_b_stall_cycles", n, 32'd1);
      end_access();

      // Stray ack in IDLE must not disturb anything
      bus.io_ack = 1'b1; bus.io_rdata = 32'h1111_1111;
      step();
      bus.io_ack = 1'b0;
      chk("stray_ack_rdata", bus.rdata, 32'h80FF_1234);
      chk("stray_ack_io_req", 32'(bus.io_req), 32'd0);

      // IO word read, ack in third IO_REQ cycle
      bus.addr = 32'hFFFF_FC70; bus.Mem_Dwidth = 2'b11; bus.Mem_sign = 1'b0;
      bus.io_rdata = 32'h0000_A5A5; bus.IORead = 1'b1;
      #1;
      chk("io_rd_c0_stall", 32'(bus.stall), 32'd1);
      chk("io_rd_c0_dm_en", 32'(bus.dm_en), 32'd0);
      step();
      chk("io_rd_c1_stall", 32'(bus.stall), 32'd1);
      chk("io_rd_io_req", 32'(bus.io_req), 32'd1);
      chk("io_rd_io_addr", 32'(bus.io_addr), 32'h070);
      chk("io_rd_io_we", 32'(bus.io_we), 32'd0);
      chk("io_rd_io_be", 32'(bus.io_be), 32'hF);
      bus.addr = 32'h0000_0000;
      step();
      chk("io_rd_c2_stall", 32'(bus.stall), 32'd1);
      chk("io_rd_io_addr_held", 32'(bus.io_addr), 32'h070);
      step();
      chk("io_rd_c3_stall", 32'(bus.stall), 32'd1);
      bus.io_ack = 1'b1;
      step();
      bus.io_ack = 1'b0;
      chk("io_rd_done_stall", 32'(bus.stall), 32'd0);
      chk("io_rd_done_io_req", 32'(bus.io_req), 32'd0);
      chk("io_rd_rdata", bus.rdata, 32'h0000_A5A5);
      end_access();

      // IO write never acked: timeout
      bus.addr = 32'h0000_0104; bus.Mem_Dwidth = 2'b11; bus.wdata = 32'hCAFE_F00D;
      bus.IOWrite = 1'b1;
      io_cycles = 0;
      berr_cnt  = 0;
      step();
      chk("io_to_io_we", 32'(bus.io_we), 32'd1);
      chk("io_to_io_wdata", bus.io_wdata, 32'hCAFE_F00D);
      chk("io_to_io_addr", 32'(bus.io_addr), 32'h104);
      for (int i = 0; i < 400; i++) begin
         if (bus.stall !== 1'b1) break;
         if (bus.io_req === 1'b1) io_cycles++;
         if (bus.bus_err === 1'b1) berr_cnt++;
         step();
      end
      chk("io_to_io_req_cycles", io_cycles, 32'd255);
      chk("io_to_bus_err_pulses", berr_cnt, 32'd1);
      chk("io_to_stall", 32'(bus.stall), 32'd0);
      chk("io_to_bus_err_done", 32'(bus.bus_err), 32'd0);
      chk("io_to_rdata", bus.rdata, 32'd0);
      end_access();

      // Misaligned word read
      mem_read("ld_w2", 32'h0000_0004, 2'b11, 1'b0, 32'h1357_9BDF, 32'h1357_9BDF);
      bus.addr = 32'h0000_0006; bus.Mem_Dwidth = 2'b11; bus.MemRead = 1'b1;
      #1;
      chk("ill_w_addr_err", 32'(bus.addr_err), 32'd1);
      chk("ill_w_dm_en", 32'(bus.dm_en), 32'd0);
      run_stall(n);
      chk("ill_w_stall_cycles", n, 32'd1);
      chk("ill_w_addr_err_done", 32'(bus.addr_err), 32'd0);
      chk("ill_w_rdata", bus.rdata, 32'd0);
      end_access();

      // Two strobes at once
      bus.addr = 32'h0000_0000; bus.MemRead = 1'b1; bus.IORead = 1'b1;
      #1;
      chk("ill_multi_addr_err", 32'(bus.addr_err), 32'd1);
      chk("ill_multi_dm_en", 32'(bus.dm_en), 32'd0);
      end_access();
      chk("ill_multi_io_req", 32'(bus.io_req), 32'd0);

      // Misaligned half store and reserved width
      bus.addr = 32'h0000_0001; bus.Mem_Dwidth = 2'b01; bus.MemWrite = 1'b1;
      #1;
      chk("ill_h_addr_err", 32'(bus.addr_err), 32'd1);
      chk("ill_h_dm_we", 32'(bus.dm_we), 32'd0);
      end_access();
      bus.addr = 32'h0000_0000; bus.Mem_Dwidth = 2'b10; bus.MemRead = 1'b1;
      #1;
      chk("ill_rsv_addr_err", 32'(bus.addr_err), 32'd1);
      end_access();

      // Reset in the middle of an IO transaction
      mem_read("ld_w3", 32'h0000_0008, 2'b11, 1'b0, 32'h2468_ACE0, 32'h2468_ACE0);
      bus.addr = 32'h0000_03F0; bus.Mem_Dwidth = 2'b00; bus.IORead = 1'b1;
      step();
      chk("rst_io_c1_io_req", 32'(bus.io_req), 32'd1);
      step();
      reset = 1'b1;
      #1;
      chk("rst_io_io_req", 32'(bus.io_req), 32'd0);
      chk("rst_io_io_addr", 32'(bus.io_addr), 32'd0);
      chk("rst_io_rdata", bus.rdata, 32'd0);
      bus.IORead = 1'b0;
      #1;
      chk("rst_io_stall", 32'(bus.stall), 32'd0);
      step();
      reset = 1'b0;
      bus.io_ack = 1'b1; bus.io_rdata = 32'hDEAD_BEEF;
      step();
      step();
      bus.io_ack = 1'b0;
      chk("rst_late_ack_rdata", bus.rdata, 32'd0);
      chk("rst_late_ack_io_req", 32'(bus.io_req), 32'd0);
      mem_read("ld_post_rst", 32'h0000_0011, 2'b00, 1'b1, 32'h0000_7F00, 32'h0000_007F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/memio_bus.md
MEMIO_BUS -- requirements
Module: memio_bus

Interface
REQ-001 SHALL have ports `clock` (in, 1: sole clock, rising edge) and `reset` (in, 1: asynchronous, active-high).
REQ-002 SHALL have CPU-side inputs, each 1 bit: `MemRead`, `MemWrite`, `IORead`, `IOWrite` (access request strobes, held stable while `stall`=1).
REQ-003 SHALL have inputs `addr` (32: byte address), `wdata` (32: store data), `Mem_Dwidth` (2: 00 byte, 01 half, 11 word, 10 reserved) and `Mem_sign` (1: sign-extend loads).
REQ-004 SHALL have outputs `rdata` (32: registered load result), `stall` (1: hold the CPU), `addr_err` (1: pulse) and `bus_err` (1: pulse).
REQ-005 SHALL have data-memory outputs `dm_en` (1), `dm_we` (4: byte enables), `dm_addr` (14: `addr`[15:2]), `dm_wdata` (32), and input `dm_rdata` (32: valid one cycle after `dm_en`).
REQ-006 SHALL have IO-bus outputs `io_req` (1), `io_we` (1), `io_addr` (10: `addr`[9:0]), `io_be` (4), `io_wdata` (32), and inputs `io_rdata` (32) and `io_ack` (1).

Function
REQ-007 SHALL implement states IDLE, MEM_WAIT, IO_REQ and DONE.
REQ-008 SHALL treat a request as present when any of the four strobes is 1, and SHALL accept it only in IDLE.
REQ-009 SHALL flag an illegal request (`addr_err`=1 for one cycle, no access, `rdata`<=0, go to DONE) on any of: more than one strobe set, width 10, word with `addr`[1:0]≠0, half with `addr`[0]≠0.
REQ-010 SHALL, for a legal MemRead in IDLE, drive `dm_en`=1 combinationally, go to MEM_WAIT, then latch the extracted `dm_rdata` into `rdata` and go to DONE.
REQ-011 SHALL, for a legal MemWrite in IDLE, drive `dm_en`=1 with `dm_we` equal to the lane mask for that cycle only, and go to DONE.
REQ-012 SHALL, for a legal IO request, register `io_addr`/`io_we`/`io_be`/`io_wdata`, go to IO_REQ, and hold `io_req`=1 and those signals stable until `io_ack`=1.
REQ-013 SHALL, in IO_REQ, on `io_ack`=1 latch the extracted `io_rdata` into `rdata` (reads only) and go to DONE in the same cycle that `io_req` is dropped.
REQ-014 SHALL count cycles in IO_REQ with an 8-bit counter; at 255 cycles without ack it SHALL pulse `bus_err`, set `rdata`<=0, drop `io_req` and go to DONE.
REQ-015 SHALL set `stall` = request present AND state≠DONE; DONE lasts exactly one cycle with `stall`=0, then returns to IDLE.
REQ-016 SHALL have latencies (stall cycles): MemRead 2, MemWrite 1, IO 1 + ack wait, illegal 1.
REQ-017 SHALL set lane masks: byte = one-hot of `addr`[1:0]; half = 0011 or 1100 selected by `addr`[1]; word = 1111.
REQ-018 SHALL replicate store data: byte into all four lanes, half into both halves.
REQ-019 SHALL extract loads little-endian from the selected lane, zero-extended when `Mem_sign`=0 and sign-extended when `Mem_sign`=1; word loads ignore `Mem_sign`.
REQ-020 SHALL ignore an `io_ack` arriving outside IO_REQ.
REQ-021 SHALL ignore strobe changes outside IDLE (inputs are sampled at acceptance only).

Reset
REQ-022 SHALL, on `reset`=1 (asynchronous, any state including mid-IO), force IDLE, timeout counter 0, `rdata`=0, `io_req`=0, and all registered IO outputs 0.
REQ-023 SHALL produce `addr_err`=`bus_err`=0 and `stall`=0 (when no request is present) from the first cycle after reset release.

Structure
REQ-024 SHALL take from shared package memio_pkg: the state enum, width codes (BYTE=00, HALF=01, WORD=11), IO_TIMEOUT=255, DM_AW=14 and IO_AW=10.
REQ-025 SHALL place lane mask generation, store replication and load extraction/extension in one combinational sub-module, memio_lane, instantiated once for each of the store and load paths.
REQ-026 SHALL keep the whole block at roughly 120-400 lines of RTL.

Verification
REQ-027 SHALL verify: MemRead byte, `addr`=0x00000013, `Mem_sign`=1, `dm_rdata`=0x80FF1234 -> `stall` high 2 cycles, `rdata`=0xFFFFFF80.
REQ-028 SHALL verify: MemWrite half, `addr`=0x00000022, `wdata`=0x0000BEEF -> one cycle `dm_we`=1100, `dm_wdata`=0xBEEFBEEF, `dm_addr`=0x008.
REQ-029 SHALL verify: IORead word, `addr`=0xFFFFFC70, `io_ack` asserted after 3 cycles with `io_rdata`=0x0000A5A5 -> `io_addr`=0x070, `rdata`=0x0000A5A5, `stall` high 4 cycles.
REQ-030 SHALL verify: IOWrite with `io_ack` never asserted -> `io_req` held 255 cycles, one-cycle `bus_err`, `rdata`=0, `stall` released.
REQ-031 SHALL verify: MemRead word at `addr`=0x00000006 -> `addr_err` pulse, `dm_en`=0, `rdata`=0, 1 stall cycle; separately, MemRead+IORead both set -> `addr_err` pulse.
REQ-032 SHALL verify: `reset` asserted in cycle 2 of IO_REQ -> `io_req`=0 immediately, state IDLE, a later `io_ack` is ignored.
